// File: rtl/lock_reset_sequencer.sv
// lock_reset_sequencer
// Turns the asynchronous PLL lock into a staged fabric reset and READY on the
// CCC output clock. Lock must stay high for a stable window before the fabric
// is released; READY follows after a further settling delay. Any lock loss
// after release drops the fabric back into reset and is recorded in a
// saturating loss counter and a sticky flag.
module lock_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_DELAY        = 16,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  LOCK,
  input  logic                  CLR_STATUS,
  output logic                  FAB_RESET,
  output logic                  READY,
  output logic [1:0]            STATE,
  output logic [LOSS_CNT_W-1:0] LOSS_COUNT,
  output logic                  LOCK_LOST
);

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABILIZE = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  // One counter serves both the stable window and the staging delay.
  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DELAY_LAST  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_SAT    = {LOSS_CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   fab_reset_q, fab_reset_d;
  logic                   ready_q, ready_d;
  logic [LOSS_CNT_W-1:0]  loss_cnt_q, loss_cnt_d, loss_cnt_base;
  logic                   lock_lost_q, lock_lost_d;
  logic                   loss_event;

  // Lock synchroniser: plain shift chain, cleared by reset so a stale lock
  // cannot leak through a reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is only ever written with non-blocking assignments
    // so every flop samples the pre-edge values regardless of statement order.
    if (RESET) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], LOCK};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next-state and counter logic for the release sequence.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_event = 1'b0;
    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = ST_STABILIZE;
      end
      ST_STABILIZE: begin
        // Dropping out before release is just a failed acquire, not a loss.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!lock_s) begin
          state_d    = ST_WAIT_LOCK;
          cnt_d      = '0;
          loss_event = 1'b1;
        end else if (cnt_q == DELAY_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin // ST_RUN
        if (!lock_s) begin
          state_d    = ST_WAIT_LOCK;
          cnt_d      = '0;
          loss_event = 1'b1;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as STATE and come straight from flops.
  always_comb begin
    fab_reset_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABILIZE);
    ready_d     = (state_d == ST_RUN);
  end

  // Status update: a clear is applied first, then a coincident loss on top of
  // it, so the loss is never hidden by the clear.
  always_comb begin
    loss_cnt_base = CLR_STATUS ? '0 : loss_cnt_q;
    loss_cnt_d    = loss_cnt_base;
    if (loss_event && (loss_cnt_base != LOSS_SAT)) loss_cnt_d = loss_cnt_base + LOSS_CNT_W'(1);
    lock_lost_d   = loss_event || (lock_lost_q && !CLR_STATUS);
  end

  // State, counter, output and status registers; reset dominates everything.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      fab_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      loss_cnt_q  <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fab_reset_q <= fab_reset_d;
      ready_q     <= ready_d;
      loss_cnt_q  <= loss_cnt_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign FAB_RESET  = fab_reset_q;
  assign READY      = ready_q;
  assign STATE      = state_q;
  assign LOSS_COUNT = loss_cnt_q;
  assign LOCK_LOST  = lock_lost_q;

endmodule

// File: tb/tb_lock_reset_sequencer.sv
// Testbench for lock_reset_sequencer (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8,
// STAGE_DELAY=4, LOSS_CNT_W=2). Stimulus pushes hand-computed expected
// output snapshots tagged with the clock edge they belong to; a monitor
// compares them on the falling edge after that clock edge.
module tb_lock_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset, lock, clr_status;
  logic       fab_reset, ready, lock_lost;
  logic [1:0] state;
  logic [1:0] loss_count;

  typedef struct {
    int         cyc;
    logic       fr;
    logic       rdy;
    logic [1:0] st;
    logic [1:0] lc;
    logic       ll;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  lock_reset_sequencer #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .STAGE_DELAY       (4),
    .LOSS_CNT_W        (2)
  ) dut (
    .CLK       (clk),
    .RESET     (reset),
    .LOCK      (lock),
    .CLR_STATUS(clr_status),
    .FAB_RESET (fab_reset),
    .READY     (ready),
    .STATE     (state),
    .LOSS_COUNT(loss_count),
    .LOCK_LOST (lock_lost)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  always @(posedge clk) cyc = cyc + 1;

  // Monitor: pops every expectation due at the current edge and compares.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: checked at edge %0d, required edge %0d", e.name, cyc, e.cyc);
      end else if (fab_reset !== e.fr || ready !== e.rdy || state !== e.st ||
                   loss_count !== e.lc || lock_lost !== e.ll) begin
        errors++;
        $display("FAIL %s @edge %0d: got fr=%b rdy=%b st=%0d lc=%0d ll=%b, want fr=%b rdy=%b st=%0d lc=%0d ll=%b",
                 e.name, cyc, fab_reset, ready, state, loss_count, lock_lost,
                 e.fr, e.rdy, e.st, e.lc, e.ll);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect a snapshot 'off' edges after the current one.
  task automatic expect_at(input int off, input logic fr, input logic rdy,
                           input logic [1:0] st, input logic [1:0] lc,
                           input logic ll, input string nm);
    exp_t e;
    e.cyc = cyc + off; e.fr = fr; e.rdy = rdy; e.st = st;
    e.lc = lc; e.ll = ll; e.name = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; lock = 1'b0; clr_status = 1'b0;
    tick(3);
    expect_at(0, 1, 0, 0, 0, 0, "reset_values");
    reset = 1'b0;
    tick(2);

    // 1: first acquire. LOCK first sampled at edge e = now+1.
    lock = 1'b1;
    expect_at(2,  1, 0, 0, 0, 0, "s1_wait_e+1");
    expect_at(3,  1, 0, 1, 0, 0, "s1_stabilize_e+2");
    expect_at(10, 1, 0, 1, 0, 0, "s1_still_reset_e+9");
    expect_at(11, 0, 0, 2, 0, 0, "s1_release_e+10");
    expect_at(14, 0, 0, 2, 0, 0, "s1_not_ready_e+13");
    expect_at(15, 0, 1, 3, 0, 0, "s1_run_e+14");
    tick(16);

    // 3: loss from RUN. LOCK first sampled low at edge f = now+1.
    lock = 1'b0;
    expect_at(2, 0, 1, 3, 0, 0, "s3_run_f+1");
    expect_at(3, 1, 0, 0, 1, 1, "s3_loss_f+2");
    tick(4);

    // 2: short lock (5 cycles) aborts STABILIZE with no loss counted.
    lock = 1'b1;
    expect_at(7, 1, 0, 1, 1, 1, "s2_stabilize");
    expect_at(8, 1, 0, 0, 1, 1, "s2_abort_no_loss");
    tick(5);
    lock = 1'b0;
    tick(5);
    lock = 1'b1;
    expect_at(3,  1, 0, 1, 1, 1, "s2_restabilize");
    expect_at(10, 1, 0, 1, 1, 1, "s2_still_reset_e+9");
    expect_at(11, 0, 0, 2, 1, 1, "s2_release_e+10");
    expect_at(15, 0, 1, 3, 1, 1, "s2_run_e+14");
    tick(16);

    // Clear status while in RUN.
    clr_status = 1'b1;
    expect_at(1, 0, 1, 3, 0, 0, "clr_in_run");
    tick(1);
    clr_status = 1'b0;

    // 4: five losses from RUN, counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      logic [1:0] lc;
      lc = (i >= 2) ? 2'd3 : 2'(i + 1);
      lock = 1'b0;
      expect_at(3, 1, 0, 0, lc, 1, $sformatf("s4_loss%0d", i + 1));
      tick(4);
      lock = 1'b1;
      expect_at(15, 0, 1, 3, lc, 1, $sformatf("s4_rerun%0d", i + 1));
      tick(16);
    end
    clr_status = 1'b1;
    expect_at(0, 0, 1, 3, 3, 1, "s4_saturated");
    expect_at(1, 0, 1, 3, 0, 0, "s4_cleared");
    tick(1);
    clr_status = 1'b0;

    // 5: one loss from RUN, then a drop in RELEASE coincident with a clear.
    lock = 1'b0;
    expect_at(3, 1, 0, 0, 1, 1, "s5_first_loss");
    tick(4);
    lock = 1'b1;
    expect_at(11, 0, 0, 2, 1, 1, "s5_release");
    expect_at(13, 0, 0, 2, 1, 1, "s5_release_late");
    expect_at(14, 1, 0, 0, 1, 1, "s5_loss_beats_clr");
    tick(11);
    lock = 1'b0;       // f = now+1, loss edge = now+3
    tick(2);
    clr_status = 1'b1; // sampled on the loss edge
    tick(1);
    clr_status = 1'b0;

    // 6: reacquire, then a 1-cycle RESET in RUN with LOCK still high.
    lock = 1'b1;
    expect_at(15, 0, 1, 3, 1, 1, "s6_run");
    tick(16);
    reset = 1'b1;
    expect_at(1,  1, 0, 0, 0, 0, "s6_reset_values");
    expect_at(2,  1, 0, 0, 0, 0, "s6_wait_after_reset");
    expect_at(11, 1, 0, 1, 0, 0, "s6_still_reset");
    expect_at(12, 0, 0, 2, 0, 0, "s6_release_10_after");
    expect_at(16, 0, 1, 3, 0, 0, "s6_run");
    tick(1);
    reset = 1'b0;
    tick(18);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
